// File: rtl/axi3_arb_pkg.sv
// rtl/axi3_arb_pkg.sv - shared types and constants for the AXI3 write arbiter
// Contents: FSM state enum, exclusive-lock encoding, BRESP/BURST encodings.
package axi3_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] LOCK_LOCKED  = 2'b10;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED  = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;

endpackage

// File: rtl/axi3_if.sv
// rtl/axi3_if.sv - AXI3 bundle (AW, W, B, AR, R) with master/slave modports
// Parameters: ID_BITS, DATA_BYTES, ADDR_BYTES.
interface axi3_if #(
    parameter int ID_BITS    = 4,
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 4
);
    logic [ID_BITS-1:0]        awid;
    logic [8*ADDR_BYTES-1:0]   awaddr;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [1:0]                awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [ID_BITS-1:0]        wid;
    logic [8*DATA_BYTES-1:0]   wdata;
    logic [DATA_BYTES-1:0]     wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [ID_BITS-1:0]        bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ID_BITS-1:0]        arid;
    logic [8*ADDR_BYTES-1:0]   araddr;
    logic [3:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [ID_BITS-1:0]        rid;
    logic [8*DATA_BYTES-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi3_rr_arb2.sv
// rtl/axi3_rr_arb2.sv - combinational 2-way round-robin pick with lock hold
// Ports: req[1:0] AW requests, last_grant, lock_hold, grant (held port),
//        pick (winning index), pick_valid (a winner exists this cycle).
module axi3_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock_hold,
    input  logic       grant,
    output logic       pick,
    output logic       pick_valid
);
    always_comb begin
        pick       = grant;
        pick_valid = 1'b0;
        if (lock_hold) begin
            // A locked sequence is in progress: only the holder may continue.
            pick       = grant;
            pick_valid = req[grant];
        end else if (req == 2'b11) begin
            pick       = ~last_grant;
            pick_valid = 1'b1;
        end else begin
            pick       = req[1];
            pick_valid = |req;
        end
    end
endmodule

// File: rtl/axi3_wr_arbiter.sv
// rtl/axi3_wr_arbiter.sv - 2:1 AXI3 write-path arbiter, burst granular, round-robin
// Ports: aclk, aresetn (async, active-low), s_axi0/s_axi1 upstream slave bundles,
//        m_axi downstream master bundle (ID MSB = port tag), err_wlast pulse,
//        grant (current or last granted port).
module axi3_wr_arbiter
    import axi3_arb_pkg::*;
#(
    parameter int DATA_BYTES    = 4,
    parameter int ADDR_BYTES    = 4,
    parameter int NUM_ID_BITS_P = 4,
    parameter int M_ID_BITS     = NUM_ID_BITS_P + 1
) (
    input  logic  aclk,
    input  logic  aresetn,
    axi3_if.slave  s_axi0,
    axi3_if.slave  s_axi1,
    axi3_if.master m_axi,
    output logic  err_wlast,
    output logic  grant
);
    arb_state_t state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic       lock_hold_q, lock_hold_d;
    logic       lock_q, lock_d;
    logic [3:0] len_q, len_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       err_q, err_d;
    logic       pick, pick_valid;
    logic       aw_hs, w_hs;

    logic [NUM_ID_BITS_P-1:0] sel_awid, sel_wid;
    logic [8*ADDR_BYTES-1:0]  sel_awaddr;
    logic [8*DATA_BYTES-1:0]  sel_wdata;
    logic [DATA_BYTES-1:0]    sel_wstrb;
    logic [3:0]               sel_awlen;
    logic [1:0]               sel_awlock;
    logic                     sel_awvalid, sel_wvalid, sel_wlast;
    logic [M_ID_BITS-1:0]     m_bid;
    logic                     btag;

    axi3_rr_arb2 u_rr (
        .req        ({s_axi1.awvalid, s_axi0.awvalid}),
        .last_grant (last_grant_q),
        .lock_hold  (lock_hold_q),
        .grant      (grant_q),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    assign sel_awid    = grant_q ? s_axi1.awid    : s_axi0.awid;
    assign sel_awaddr  = grant_q ? s_axi1.awaddr  : s_axi0.awaddr;
    assign sel_awlen   = grant_q ? s_axi1.awlen   : s_axi0.awlen;
    assign sel_awlock  = grant_q ? s_axi1.awlock  : s_axi0.awlock;
    assign sel_awvalid = grant_q ? s_axi1.awvalid : s_axi0.awvalid;
    assign sel_wid     = grant_q ? s_axi1.wid     : s_axi0.wid;
    assign sel_wdata   = grant_q ? s_axi1.wdata   : s_axi0.wdata;
    assign sel_wstrb   = grant_q ? s_axi1.wstrb   : s_axi0.wstrb;
    assign sel_wlast   = grant_q ? s_axi1.wlast   : s_axi0.wlast;
    assign sel_wvalid  = grant_q ? s_axi1.wvalid  : s_axi0.wvalid;

    // AW channel: open only in ADDR, routed from the granted port.
    assign m_axi.awid     = {grant_q, sel_awid};
    assign m_axi.awaddr   = sel_awaddr;
    assign m_axi.awlen    = sel_awlen;
    assign m_axi.awsize   = grant_q ? s_axi1.awsize  : s_axi0.awsize;
    assign m_axi.awburst  = grant_q ? s_axi1.awburst : s_axi0.awburst;
    assign m_axi.awlock   = sel_awlock;
    assign m_axi.awcache  = grant_q ? s_axi1.awcache : s_axi0.awcache;
    assign m_axi.awprot   = grant_q ? s_axi1.awprot  : s_axi0.awprot;
    assign m_axi.awvalid  = (state_q == ADDR) && sel_awvalid;
    assign s_axi0.awready = (state_q == ADDR) && !grant_q && m_axi.awready;
    assign s_axi1.awready = (state_q == ADDR) &&  grant_q && m_axi.awready;
    assign aw_hs          = m_axi.awvalid && m_axi.awready;

    // W channel: open only in DATA; the other port's early data is stalled.
    assign m_axi.wid      = {grant_q, sel_wid};
    assign m_axi.wdata    = sel_wdata;
    assign m_axi.wstrb    = sel_wstrb;
    assign m_axi.wlast    = sel_wlast;
    assign m_axi.wvalid   = (state_q == DATA) && sel_wvalid;
    assign s_axi0.wready  = (state_q == DATA) && !grant_q && m_axi.wready;
    assign s_axi1.wready  = (state_q == DATA) &&  grant_q && m_axi.wready;
    assign w_hs           = m_axi.wvalid && m_axi.wready;

    // B channel: routed purely by the ID tag, so any number may be outstanding.
    assign m_bid          = m_axi.bid;
    assign btag           = m_bid[M_ID_BITS-1];
    assign s_axi0.bvalid  = m_axi.bvalid && !btag;
    assign s_axi1.bvalid  = m_axi.bvalid &&  btag;
    assign s_axi0.bid     = m_bid[NUM_ID_BITS_P-1:0];
    assign s_axi1.bid     = m_bid[NUM_ID_BITS_P-1:0];
    assign s_axi0.bresp   = m_axi.bresp;
    assign s_axi1.bresp   = m_axi.bresp;
    assign m_axi.bready   = btag ? s_axi1.bready : s_axi0.bready;

    // Read path is owned by a separate arbiter; keep it parked.
    assign m_axi.arid     = '0;
    assign m_axi.araddr   = '0;
    assign m_axi.arlen    = '0;
    assign m_axi.arsize   = '0;
    assign m_axi.arburst  = '0;
    assign m_axi.arvalid  = 1'b0;
    assign m_axi.rready   = 1'b1;
    assign s_axi0.arready = 1'b0;
    assign s_axi1.arready = 1'b0;
    assign s_axi0.rid     = '0;
    assign s_axi1.rid     = '0;
    assign s_axi0.rdata   = '0;
    assign s_axi1.rdata   = '0;
    assign s_axi0.rresp   = '0;
    assign s_axi1.rresp   = '0;
    assign s_axi0.rlast   = 1'b0;
    assign s_axi1.rlast   = 1'b0;
    assign s_axi0.rvalid  = 1'b0;
    assign s_axi1.rvalid  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{s_axi0.arid, s_axi0.araddr, s_axi0.arlen, s_axi0.arsize,
                         s_axi0.arburst, s_axi0.arvalid, s_axi0.rready,
                         s_axi1.arid, s_axi1.araddr, s_axi1.arlen, s_axi1.arsize,
                         s_axi1.arburst, s_axi1.arvalid, s_axi1.rready,
                         m_axi.arready, m_axi.rid, m_axi.rdata, m_axi.rresp,
                         m_axi.rlast, m_axi.rvalid};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lock_hold_d  = lock_hold_q;
        lock_d       = lock_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_hs) begin
                    len_d      = sel_awlen;
                    beat_cnt_d = 4'd0;
                    lock_d     = (sel_awlock == LOCK_LOCKED);
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    err_d      = sel_wlast ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q);
                    // Termination follows wlast alone; a length mismatch is only flagged.
                    if (sel_wlast) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                        lock_hold_d  = lock_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lock_hold_q  <= 1'b0;
            lock_q       <= 1'b0;
            len_q        <= 4'd0;
            beat_cnt_q   <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lock_hold_q  <= lock_hold_d;
            lock_q       <= lock_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

    assign err_wlast = err_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_axi3_wr_arbiter.sv
// tb/tb_axi3_wr_arbiter.sv - scoreboard bench for axi3_wr_arbiter
module tb_axi3_wr_arbiter;
    import axi3_arb_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    logic err_wlast, grant;
    always #5 aclk = ~aclk;

    axi3_if #(.ID_BITS(4)) s0_if ();
    axi3_if #(.ID_BITS(4)) s1_if ();
    axi3_if #(.ID_BITS(5)) m_if ();

    axi3_wr_arbiter dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axi0    (s0_if),
        .s_axi1    (s1_if),
        .m_axi     (m_if),
        .err_wlast (err_wlast),
        .grant     (grant)
    );

    // Upstream master drive state, one slot per port.
    logic        awvalid_d [2];
    logic [3:0]  awid_d    [2];
    logic [31:0] awaddr_d  [2];
    logic [3:0]  awlen_d   [2];
    logic [1:0]  awlock_d  [2];
    logic        wvalid_d  [2];
    logic [3:0]  wid_d     [2];
    logic [31:0] wdata_d   [2];
    logic        wlast_d   [2];
    logic        bready_d  [2];
    logic        m_awready, m_wready, m_bvalid;
    logic [4:0]  m_bid;
    logic [1:0]  m_bresp;

    assign s0_if.awvalid = awvalid_d[0]; assign s1_if.awvalid = awvalid_d[1];
    assign s0_if.awid    = awid_d[0];    assign s1_if.awid    = awid_d[1];
    assign s0_if.awaddr  = awaddr_d[0];  assign s1_if.awaddr  = awaddr_d[1];
    assign s0_if.awlen   = awlen_d[0];   assign s1_if.awlen   = awlen_d[1];
    assign s0_if.awlock  = awlock_d[0];  assign s1_if.awlock  = awlock_d[1];
    assign s0_if.awsize  = 3'd2;         assign s1_if.awsize  = 3'd2;
    assign s0_if.awburst = BURST_INCR;   assign s1_if.awburst = BURST_INCR;
    assign s0_if.awcache = 4'd0;         assign s1_if.awcache = 4'd0;
    assign s0_if.awprot  = 3'd0;         assign s1_if.awprot  = 3'd0;
    assign s0_if.wvalid  = wvalid_d[0];  assign s1_if.wvalid  = wvalid_d[1];
    assign s0_if.wid     = wid_d[0];     assign s1_if.wid     = wid_d[1];
    assign s0_if.wdata   = wdata_d[0];   assign s1_if.wdata   = wdata_d[1];
    assign s0_if.wlast   = wlast_d[0];   assign s1_if.wlast   = wlast_d[1];
    assign s0_if.wstrb   = 4'hF;         assign s1_if.wstrb   = 4'hF;
    assign s0_if.bready  = bready_d[0];  assign s1_if.bready  = bready_d[1];
    assign s0_if.arid = '0; assign s0_if.araddr = '0; assign s0_if.arlen = '0;
    assign s0_if.arsize = '0; assign s0_if.arburst = '0; assign s0_if.arvalid = 1'b0;
    assign s0_if.rready = 1'b1;
    assign s1_if.arid = '0; assign s1_if.araddr = '0; assign s1_if.arlen = '0;
    assign s1_if.arsize = '0; assign s1_if.arburst = '0; assign s1_if.arvalid = 1'b0;
    assign s1_if.rready = 1'b1;
    assign m_if.awready = m_awready;
    assign m_if.wready  = m_wready;
    assign m_if.bvalid  = m_bvalid;
    assign m_if.bid     = m_bid;
    assign m_if.bresp   = m_bresp;
    assign m_if.arready = 1'b0; assign m_if.rid = '0; assign m_if.rdata = '0;
    assign m_if.rresp = '0; assign m_if.rlast = 1'b0; assign m_if.rvalid = 1'b0;

    logic [1:0] awready_o, wready_o;
    assign awready_o = {s1_if.awready, s0_if.awready};
    assign wready_o  = {s1_if.wready, s0_if.wready};

    typedef struct packed { logic [4:0] id; logic [31:0] addr; logic [3:0] len; } aw_t;
    typedef struct packed { logic [4:0] id; logic [31:0] data; logic last; } w_t;
    aw_t aw_q[$];
    w_t  w_q[$];
    int  err_exp[$];
    int  exp_beats = 0;
    int  w_seen = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] wdat(input int p, input logic [3:0] id, input int b);
        return 32'hA000_0000 | 32'(p << 16) | (32'(id) << 8) | 32'(b);
    endfunction

    task automatic expect_burst(input int p, input logic [3:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input int nbeats);
        logic last;
        aw_q.push_back({p[0], id, addr, len});
        for (int b = 0; b < nbeats; b++) begin
            last = (b == nbeats - 1);
            w_q.push_back({p[0], id, wdat(p, id, b), last});
            if (last ? (b != int'(len)) : (b == int'(len)))
                err_exp.push_back(exp_beats + b + 1);
        end
        exp_beats += nbeats;
    endtask

    // Wait for the handshake to be pending at the negedge, then step past the edge.
    task automatic wait_ready(input int p, input logic is_w, input string tag);
        int t;
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!(is_w ? wready_o[p] : awready_o[p]) && t < 500);
        if (t >= 500) check(tag, 64'd0, 64'd1);
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_aw(input int p, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] lock);
        awvalid_d[p] = 1'b1; awid_d[p] = id; awaddr_d[p] = addr;
        awlen_d[p] = len; awlock_d[p] = lock;
        wait_ready(p, 1'b0, "aw_timeout");
        awvalid_d[p] = 1'b0;
    endtask

    task automatic drive_beat(input int p, input logic [3:0] id, input int b, input logic last);
        wvalid_d[p] = 1'b1; wid_d[p] = id; wdata_d[p] = wdat(p, id, b); wlast_d[p] = last;
        wait_ready(p, 1'b1, "w_timeout");
        wvalid_d[p] = 1'b0;
    endtask

    task automatic drive_burst(input int p, input logic [3:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input int nbeats, input logic [1:0] lock);
        drive_aw(p, id, addr, len, lock);
        for (int b = 0; b < nbeats; b++) drive_beat(p, id, b, b == nbeats - 1);
    endtask

    // Scoreboard monitor; err is checked before the W counter advances.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (err_wlast) begin
                if (err_exp.size() == 0) check("err_unexpected", 64'd1, 64'd0);
                else check("err_beat", 64'(w_seen), 64'(err_exp.pop_front()));
            end
            if (m_if.awvalid && m_if.awready) begin
                if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("aw", {m_if.awid, m_if.awaddr, m_if.awlen}, aw_q.pop_front());
            end
            if (m_if.wvalid && m_if.wready) begin
                w_seen++;
                if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("w", {m_if.wid, m_if.wdata, m_if.wlast}, w_q.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int p = 0; p < 2; p++) begin
            awvalid_d[p] = 0; awid_d[p] = 0; awaddr_d[p] = 0; awlen_d[p] = 0; awlock_d[p] = 0;
            wvalid_d[p] = 0; wid_d[p] = 0; wdata_d[p] = 0; wlast_d[p] = 0; bready_d[p] = 0;
        end
        m_awready = 1; m_wready = 1; m_bvalid = 0; m_bid = 0; m_bresp = BRESP_OKAY;

        // Reset values
        repeat (3) @(negedge aclk);
        check("rst_m_awvalid", m_if.awvalid, 0);
        check("rst_m_wvalid", m_if.wvalid, 0);
        check("rst_awready", {s1_if.awready, s0_if.awready}, 0);
        check("rst_wready", {s1_if.wready, s0_if.wready}, 0);
        check("rst_grant", grant, 0);
        check("rst_err", err_wlast, 0);
        check("rst_state", 64'(dut.state_q), 64'(IDLE));
        check("rd_parked", {m_if.arvalid, m_if.rready, s0_if.rvalid, s1_if.arready}, 4'b0100);
        @(posedge aclk); #1;
        aresetn = 1;

        // Ties after reset: port 0 first, both rounds
        expect_burst(0, 4'h1, 32'h1000, 4'd1, 2);
        expect_burst(1, 4'h2, 32'h2000, 4'd2, 3);
        fork
            drive_burst(0, 4'h1, 32'h1000, 4'd1, 2, 2'b00);
            drive_burst(1, 4'h2, 32'h2000, 4'd2, 3, 2'b00);
        join
        check("tie1_grant", grant, 1);
        expect_burst(0, 4'h4, 32'h1100, 4'd0, 1);
        expect_burst(1, 4'h6, 32'h2100, 4'd0, 1);
        fork
            drive_burst(0, 4'h4, 32'h1100, 4'd0, 1, 2'b00);
            drive_burst(1, 4'h6, 32'h2100, 4'd0, 1, 2'b00);
        join

        // Single port 0 burst with latency check
        expect_burst(0, 4'h5, 32'h3000, 4'd3, 4);
        fork
            drive_burst(0, 4'h5, 32'h3000, 4'd3, 4, 2'b00);
            begin
                @(negedge aclk); check("lat_cyc1_awvalid", m_if.awvalid, 0);
                @(negedge aclk); check("lat_cyc2_awvalid", m_if.awvalid, 1);
            end
        join

        // Locked burst keeps port 1 granted over a waiting port 0
        expect_burst(1, 4'hA, 32'h4000, 4'd1, 2);
        expect_burst(1, 4'hB, 32'h4100, 4'd0, 1);
        expect_burst(0, 4'h3, 32'h5000, 4'd2, 3);
        fork
            begin
                drive_burst(1, 4'hA, 32'h4000, 4'd1, 2, LOCK_LOCKED);
                drive_burst(1, 4'hB, 32'h4100, 4'd0, 1, 2'b00);
            end
            begin
                repeat (2) @(posedge aclk);
                #1;
                drive_burst(0, 4'h3, 32'h5000, 4'd2, 3, 2'b00);
            end
        join
        check("lock_last_grant", grant, 0);

        // WLAST too early, then too late
        expect_burst(0, 4'h7, 32'h6000, 4'd1, 1);
        drive_burst(0, 4'h7, 32'h6000, 4'd1, 1, 2'b00);
        check("early_idle", 64'(dut.state_q), 64'(IDLE));
        expect_burst(0, 4'h8, 32'h6100, 4'd1, 3);
        drive_burst(0, 4'h8, 32'h6100, 4'd1, 3, 2'b00);
        check("late_idle", 64'(dut.state_q), 64'(IDLE));
        repeat (2) @(posedge aclk);
        #1;

        // B routing by tag
        bready_d[0] = 1; bready_d[1] = 0;
        m_bvalid = 1; m_bid = 5'h13; m_bresp = BRESP_OKAY;
        @(negedge aclk);
        check("b1_route", {s1_if.bvalid, s0_if.bvalid}, 2'b10);
        check("b1_bid", s1_if.bid, 4'h3);
        check("b1_bready_blocked", m_if.bready, 0);
        @(posedge aclk); #1;
        bready_d[1] = 1;
        @(negedge aclk);
        check("b1_bready", m_if.bready, 1);
        @(posedge aclk); #1;
        m_bid = 5'h02; m_bresp = BRESP_SLVERR; bready_d[1] = 0;
        @(negedge aclk);
        check("b2_route", {s1_if.bvalid, s0_if.bvalid}, 2'b01);
        check("b2_bid_bresp", {s0_if.bid, s0_if.bresp}, {4'h2, BRESP_SLVERR});
        check("b2_bready", m_if.bready, 1);
        @(posedge aclk); #1;
        m_bvalid = 0;

        // Reset in the middle of a 4-beat burst
        aw_q.push_back({1'b0, 4'h9, 32'h7000, 4'd3});
        w_q.push_back({1'b0, 4'h9, wdat(0, 4'h9, 0), 1'b0});
        exp_beats += 1;
        drive_aw(0, 4'h9, 32'h7000, 4'd3, 2'b00);
        drive_beat(0, 4'h9, 0, 1'b0);
        wvalid_d[0] = 1; wdata_d[0] = wdat(0, 4'h9, 1); wlast_d[0] = 0;
        #2;
        aresetn = 0;
        @(negedge aclk);
        check("mrst_valids", {m_if.awvalid, m_if.wvalid}, 0);
        check("mrst_readys", {s1_if.awready, s0_if.awready, s1_if.wready, s0_if.wready}, 0);
        check("mrst_state", 64'(dut.state_q), 64'(IDLE));
        wvalid_d[0] = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        expect_burst(1, 4'hC, 32'h8000, 4'd1, 2);
        drive_burst(1, 4'hC, 32'h8000, 4'd1, 2, 2'b00);
        check("post_rst_grant", grant, 1);
        repeat (3) @(posedge aclk);

        check("aw_q_drained", aw_q.size(), 0);
        check("w_q_drained", w_q.size(), 0);
        check("err_exp_drained", err_exp.size(), 0);
        check("w_beats_total", w_seen, exp_beats);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
